// File: rtl/mc_ctrl_pkg.sv
// Shared opcode constants, state encodings and control-field codes for the
// multi-cycle control unit.
package mc_ctrl_pkg;

  localparam logic [5:0] OPC_ADD   = 6'b000000;
  localparam logic [5:0] OPC_SUB   = 6'b000001;
  localparam logic [5:0] OPC_ADDIU = 6'b000010;
  localparam logic [5:0] OPC_ANDI  = 6'b010000;
  localparam logic [5:0] OPC_AND   = 6'b010001;
  localparam logic [5:0] OPC_ORI   = 6'b010010;
  localparam logic [5:0] OPC_OR    = 6'b010011;
  localparam logic [5:0] OPC_SLL   = 6'b011000;
  localparam logic [5:0] OPC_SLTI  = 6'b100110;
  localparam logic [5:0] OPC_SW    = 6'b110000;
  localparam logic [5:0] OPC_LW    = 6'b110001;
  localparam logic [5:0] OPC_BEQ   = 6'b110100;
  localparam logic [5:0] OPC_BNE   = 6'b110101;
  localparam logic [5:0] OPC_BLTZ  = 6'b110110;
  localparam logic [5:0] OPC_J     = 6'b111000;
  localparam logic [5:0] OPC_JR    = 6'b111001;
  localparam logic [5:0] OPC_JAL   = 6'b111010;
  localparam logic [5:0] OPC_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b111
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_BLTZ,
    CL_J, CL_JR, CL_JAL, CL_HALT, CL_ILL
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic [1:0] reg_dst;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decoder: instruction class, ALU controls, register
// destination and legality.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] Op,
  output dec_t            dec_o
);

  always_comb begin
    dec_o         = '0;
    dec_o.cls     = CL_ILL;
    dec_o.alu_op  = ALU_ADD;
    dec_o.ext_sel = 1'b1;
    dec_o.reg_dst = RD_RT;
    dec_o.legal   = 1'b1;
    case (Op)
      OP_W'(OPC_ADD):   begin dec_o.cls = CL_ALU_R; dec_o.reg_dst = RD_RD; end
      OP_W'(OPC_SUB):   begin dec_o.cls = CL_ALU_R; dec_o.reg_dst = RD_RD; dec_o.alu_op = ALU_SUB; end
      OP_W'(OPC_AND):   begin dec_o.cls = CL_ALU_R; dec_o.reg_dst = RD_RD; dec_o.alu_op = ALU_AND; end
      OP_W'(OPC_OR):    begin dec_o.cls = CL_ALU_R; dec_o.reg_dst = RD_RD; dec_o.alu_op = ALU_OR; end
      OP_W'(OPC_SLL): begin
        dec_o.cls       = CL_ALU_R;
        dec_o.reg_dst   = RD_RD;
        dec_o.alu_op    = ALU_SLL;
        dec_o.alu_src_a = 1'b1;
      end
      OP_W'(OPC_ADDIU): begin dec_o.cls = CL_ALU_I; dec_o.alu_src_b = 1'b1; end
      // Logical immediates are zero-extended, everything else sign-extended
      OP_W'(OPC_ANDI): begin
        dec_o.cls = CL_ALU_I; dec_o.alu_src_b = 1'b1; dec_o.alu_op = ALU_AND; dec_o.ext_sel = 1'b0;
      end
      OP_W'(OPC_ORI): begin
        dec_o.cls = CL_ALU_I; dec_o.alu_src_b = 1'b1; dec_o.alu_op = ALU_OR; dec_o.ext_sel = 1'b0;
      end
      OP_W'(OPC_SLTI):  begin dec_o.cls = CL_ALU_I; dec_o.alu_src_b = 1'b1; dec_o.alu_op = ALU_SLT; end
      OP_W'(OPC_SW):    begin dec_o.cls = CL_SW; dec_o.alu_src_b = 1'b1; end
      OP_W'(OPC_LW):    begin dec_o.cls = CL_LW; dec_o.alu_src_b = 1'b1; end
      OP_W'(OPC_BEQ):   begin dec_o.cls = CL_BEQ;  dec_o.alu_op = ALU_SUB; end
      OP_W'(OPC_BNE):   begin dec_o.cls = CL_BNE;  dec_o.alu_op = ALU_SUB; end
      OP_W'(OPC_BLTZ):  begin dec_o.cls = CL_BLTZ; dec_o.alu_op = ALU_SUB; end
      OP_W'(OPC_J):     dec_o.cls = CL_J;
      OP_W'(OPC_JR):    dec_o.cls = CL_JR;
      OP_W'(OPC_JAL):   begin dec_o.cls = CL_JAL; dec_o.reg_dst = RD_RA; end
      OP_W'(OPC_HALT):  dec_o.cls = CL_HALT;
      default: begin
        dec_o.cls   = CL_ILL;
        dec_o.legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control FSM with memory handshakes, HALT and illegal-opcode
// detection. Define MC_CTRL_WDOG_EN to add the memory-wait watchdog.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int WDOG_CYCLES = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [OP_W-1:0] Op,
  input  logic            Zero,
  input  logic            Sign,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  output logic            imem_req,
  output logic            PCWre,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic            DBDataSrc,
  output logic            RegWre,
  output logic            WrRegDSrc,
  output logic            InsMemRw,
  output logic            mRD,
  output logic            mWR,
  output logic            IRWre,
  output logic            ExtSel,
  output logic [1:0]      PCSrc,
  output logic [1:0]      RegDst,
  output logic [2:0]      ALUOp,
  output logic [2:0]      State,
  output logic            halted,
  output logic            ill_op,
  output logic            bus_err
);

  state_e state_q, state_d;
  logic   ill_op_q, bus_err_q;
  logic   wdog_trip;
  logic   br_taken;
  dec_t   dec;

  mc_ctrl_decode #(.OP_W(OP_W)) u_decode (
    .Op    (Op),
    .dec_o (dec)
  );

`ifdef MC_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            waiting;

  // A wait that does not trip always stays in the same state, so the count
  // can advance without looking at the next-state logic.
  always_comb begin
    waiting   = (state_q == ST_IF && !imem_ack) || (state_q == ST_MEM && !dmem_ack);
    wdog_trip = waiting && (wdog_q == WD_W'(WDOG_CYCLES - 1));
    wdog_d    = (waiting && !wdog_trip) ? wdog_q + WD_W'(1) : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES != 0);
  assign wdog_trip       = 1'b0;
`endif

  always_comb begin
    case (dec.cls)
      CL_BEQ:  br_taken = Zero;
      CL_BNE:  br_taken = !Zero;
      CL_BLTZ: br_taken = Sign;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    PCWre     = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    RegWre    = 1'b0;
    WrRegDSrc = 1'b0;
    InsMemRw  = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    PCSrc     = PC_NEXT;
    RegDst    = RD_RA;
    ALUOp     = ALU_ADD;
    case (state_q)
      ST_IF: begin
        imem_req = 1'b1;
        InsMemRw = 1'b1;
        IRWre    = imem_ack;
        if (imem_ack)       state_d = ST_ID;
        else if (wdog_trip) state_d = ST_HALT;
      end
      ST_ID: begin
        case (dec.cls)
          CL_J:  begin PCWre = 1'b1; PCSrc = PC_JUMP; state_d = ST_IF; end
          CL_JR: begin PCWre = 1'b1; PCSrc = PC_REG;  state_d = ST_IF; end
          CL_JAL: begin
            PCWre   = 1'b1;
            PCSrc   = PC_JUMP;
            RegWre  = 1'b1;
            RegDst  = RD_RA;
            state_d = ST_IF;
          end
          CL_HALT, CL_ILL: state_d = ST_HALT;
          default:         state_d = ST_EXE;
        endcase
      end
      ST_EXE: begin
        ALUOp   = dec.alu_op;
        ALUSrcA = dec.alu_src_a;
        ALUSrcB = dec.alu_src_b;
        ExtSel  = dec.ext_sel;
        case (dec.cls)
          CL_BEQ, CL_BNE, CL_BLTZ: begin
            PCWre   = 1'b1;
            PCSrc   = br_taken ? PC_BRANCH : PC_NEXT;
            state_d = ST_IF;
          end
          CL_LW, CL_SW: state_d = ST_MEM;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mRD = (dec.cls == CL_LW);
        mWR = (dec.cls == CL_SW);
        if (dmem_ack) begin
          if (dec.cls == CL_SW) begin
            PCWre   = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end else if (wdog_trip) begin
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
        DBDataSrc = (dec.cls == CL_LW);
        RegDst    = dec.reg_dst;
        state_d   = ST_IF;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IF;
      ill_op_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ID && !dec.legal) ill_op_q  <= 1'b1;
      if (wdog_trip)                      bus_err_q <= 1'b1;
    end
  end

  assign State   = state_q;
  assign halted  = (state_q == ST_HALT);
  assign ill_op  = ill_op_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Randomized instruction-level bench for mc_ctrl_unit with a per-cycle
// reference model built from instruction phase sequences.
`timescale 1ns/1ps
module tb_mc_ctrl_unit;

`ifdef MC_CTRL_WDOG_EN
  localparam int WDOG = 4;
`else
  localparam int WDOG = 16;
`endif

  localparam logic [2:0] P_IF = 3'd0, P_ID = 3'd1, P_EXE = 3'd2, P_MEM = 3'd3,
                         P_WB = 3'd4, P_HALT = 3'd7;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] Op = '0;
  logic       Zero = 1'b0, Sign = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       imem_req, PCWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc;
  logic       InsMemRw, mRD, mWR, IRWre, ExtSel, halted, ill_op, bus_err;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, State;

  always #5 CLK = ~CLK;

  mc_ctrl_unit #(.OP_W(6), .WDOG_CYCLES(WDOG)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .Sign(Sign),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .PCWre(PCWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
    .RegWre(RegWre), .WrRegDSrc(WrRegDSrc), .InsMemRw(InsMemRw), .mRD(mRD),
    .mWR(mWR), .IRWre(IRWre), .ExtSel(ExtSel), .PCSrc(PCSrc), .RegDst(RegDst),
    .ALUOp(ALUOp), .State(State), .halted(halted), .ill_op(ill_op), .bus_err(bus_err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic imem_req, PCWre, ALUSrcA, ALUSrcB, DBDataSrc, RegWre, WrRegDSrc;
    logic InsMemRw, mRD, mWR, IRWre, ExtSel;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp;
    logic halted, ill_op, bus_err;
  } vec_t;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JR, K_JAL, K_HALT, K_ILL} kind_e;

  int   checks = 0, errors = 0;
  vec_t exp_v;
  logic exp_valid = 1'b0;
  int   cyc_idx = 0, pcwre_cnt = 0, mrd_cnt = 0, last_lat = -1;
  logic [1:0] last_pcsrc;
  logic last_regwre;
  logic ill_m = 1'b0, berr_m = 1'b0;

  logic [5:0] legal_ops [18] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000,
    6'b010001, 6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b110000, 6'b110001,
    6'b110100, 6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010, 6'b111111};

  function automatic kind_e kind_of(logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b010001, 6'b010011, 6'b011000: return K_R;
      6'b000010, 6'b010000, 6'b010010, 6'b100110:            return K_I;
      6'b110000: return K_SW;
      6'b110001: return K_LW;
      6'b110100, 6'b110101, 6'b110110: return K_BR;
      6'b111000: return K_J;
      6'b111001: return K_JR;
      6'b111010: return K_JAL;
      6'b111111: return K_HALT;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] op);
    case (op)
      6'b000001, 6'b110100, 6'b110101, 6'b110110: return 3'b001;
      6'b011000:            return 3'b010;
      6'b010010, 6'b010011: return 3'b011;
      6'b010000, 6'b010001: return 3'b100;
      6'b100110:            return 3'b110;
      default:              return 3'b000;
    endcase
  endfunction

  function automatic logic taken(logic [5:0] op, logic z, logic s);
    if (op == 6'b110100) return z;
    if (op == 6'b110101) return !z;
    return s;
  endfunction

  function automatic vec_t exp_vec(logic [2:0] ph, logic [5:0] op, logic z, logic s,
                                   logic iack, logic dack, logic ill, logic berr);
    vec_t  v;
    kind_e k;
    v = '0;
    k = kind_of(op);
    v.st = ph;
    v.halted = (ph == P_HALT);
    v.ill_op = ill;
    v.bus_err = berr;
    case (ph)
      P_IF: begin v.imem_req = 1; v.InsMemRw = 1; v.IRWre = iack; end
      P_ID: begin
        if (k == K_J || k == K_JAL) begin v.PCWre = 1; v.PCSrc = 2'b11; end
        if (k == K_JR)  begin v.PCWre = 1; v.PCSrc = 2'b10; end
        if (k == K_JAL) begin v.RegWre = 1; v.RegDst = 2'b00; end
      end
      P_EXE: begin
        v.ALUOp   = alu_of(op);
        v.ALUSrcA = (op == 6'b011000);
        v.ALUSrcB = (k == K_I || k == K_LW || k == K_SW);
        v.ExtSel  = !(op == 6'b010000 || op == 6'b010010);
        if (k == K_BR) begin v.PCWre = 1; v.PCSrc = taken(op, z, s) ? 2'b01 : 2'b00; end
      end
      P_MEM: begin v.mRD = (k == K_LW); v.mWR = (k == K_SW); v.PCWre = (k == K_SW) && dack; end
      P_WB: begin
        v.RegWre = 1; v.WrRegDSrc = 1; v.PCWre = 1;
        v.DBDataSrc = (k == K_LW);
        v.RegDst = (k == K_R) ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
    return v;
  endfunction

  always @(negedge CLK) begin
    vec_t got;
    got = '{st: State, imem_req: imem_req, PCWre: PCWre, ALUSrcA: ALUSrcA, ALUSrcB: ALUSrcB,
            DBDataSrc: DBDataSrc, RegWre: RegWre, WrRegDSrc: WrRegDSrc, InsMemRw: InsMemRw,
            mRD: mRD, mWR: mWR, IRWre: IRWre, ExtSel: ExtSel, PCSrc: PCSrc, RegDst: RegDst,
            ALUOp: ALUOp, halted: halted, ill_op: ill_op, bus_err: bus_err};
    if (exp_valid) begin
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t op=%b got=%h required=%h", $time, Op, got, exp_v);
      end
    end
    if (PCWre === 1'b1) begin
      pcwre_cnt++;
      last_lat    = cyc_idx + 1;
      last_pcsrc  = PCSrc;
      last_regwre = RegWre;
    end
    if (mRD === 1'b1) mrd_cnt++;
  end

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge CLK); #1;
      RST = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      ill_m = 1'b0; berr_m = 1'b0;
      exp_v = exp_vec(P_IF, Op, Zero, Sign, imem_ack, dmem_ack, 1'b0, 1'b0);
      exp_valid = (c > 0);
    end
  endtask

  // Plays one instruction; returns 1 if it ended in HALT (caller resets)
  task automatic run_instr(input logic [5:0] op, input logic z, input logic s,
                           input int iw, input int dw, input int abort_at,
                           output logic ended_halt);
    logic [2:0] ph[$];
    logic       ak[$];
    kind_e      k;
    logic       trip;
    int         n, base;
    k = kind_of(op);
    trip = 1'b0;
    n = iw + 1;
`ifdef MC_CTRL_WDOG_EN
    if (iw >= WDOG) begin n = WDOG; trip = 1'b1; end
`endif
    for (int j = 0; j < n; j++) begin ph.push_back(P_IF); ak.push_back(j == iw); end
    if (!trip) begin
      ph.push_back(P_ID); ak.push_back(1'b0);
      if (k == K_BR || k == K_R || k == K_I || k == K_LW || k == K_SW) begin
        ph.push_back(P_EXE); ak.push_back(1'b0);
      end
      if (k == K_LW || k == K_SW) begin
        n = dw + 1;
`ifdef MC_CTRL_WDOG_EN
        if (dw >= WDOG) begin n = WDOG; trip = 1'b1; end
`endif
        for (int j = 0; j < n; j++) begin ph.push_back(P_MEM); ak.push_back(j == dw); end
      end
      if (!trip && (k == K_R || k == K_I || k == K_LW)) begin
        ph.push_back(P_WB); ak.push_back(1'b0);
      end
    end
    ended_halt = trip || k == K_HALT || k == K_ILL;
    if (ended_halt) begin
      abort_at = -1;
      for (int j = 0; j < 3; j++) begin ph.push_back(P_HALT); ak.push_back(1'b0); end
    end
    pcwre_cnt = 0; mrd_cnt = 0; last_lat = -1;
    for (int c = 0; c < ph.size(); c++) begin
      @(posedge CLK); #1;
      cyc_idx = c;
      RST  = (c == abort_at);
      Op   = (ph[c] == P_IF) ? 6'($urandom_range(0, 63)) : op;
      Zero = (ph[c] == P_EXE) ? z : 1'($urandom_range(0, 1));
      Sign = (ph[c] == P_EXE) ? s : 1'($urandom_range(0, 1));
      imem_ack = (ph[c] == P_IF)  ? ak[c] : 1'($urandom_range(0, 1));
      dmem_ack = (ph[c] == P_MEM) ? ak[c] : 1'($urandom_range(0, 1));
      if (ph[c] == P_HALT && ph[c-1] == P_ID && k == K_ILL) ill_m = 1'b1;
      if (ph[c] == P_HALT && (ph[c-1] == P_IF || ph[c-1] == P_MEM)) berr_m = 1'b1;
      exp_v = exp_vec(ph[c], Op, Zero, Sign, imem_ack, dmem_ack, ill_m, berr_m);
      exp_valid = 1'b1;
      if (RST) break;
    end
    @(negedge CLK); #1;
    if (abort_at >= 0 && abort_at < ph.size()) begin
      ill_m = 1'b0; berr_m = 1'b0;
    end else if (!ended_halt) begin
      case (k)
        K_J, K_JR, K_JAL: base = 2;
        K_BR:             base = 3;
        K_LW:             base = 5;
        default:          base = 4;
      endcase
      chk("latency", last_lat, base + iw + ((k == K_LW || k == K_SW) ? dw : 0));
      chk("pcwre_pulses", pcwre_cnt, 1);
    end
  endtask

  initial begin
    logic h;
    do_reset(3);
    // Reset state seen directly, with the bench's own literal values
    chk("reset_state", int'(State), 0);
    chk("reset_imem_req", int'(imem_req), 1);
    chk("reset_flags", int'({halted, ill_op, bus_err}), 0);

    run_instr(6'b000000, 0, 0, 0, 0, -1, h);
    chk("add_lat", last_lat, 4);
    run_instr(6'b110001, 0, 0, 0, 3, -1, h);
    chk("lw_lat", last_lat, 8);
    chk("lw_mrd_cycles", mrd_cnt, 4);
    run_instr(6'b110100, 1, 0, 0, 0, -1, h);
    chk("beq_taken_pcsrc", int'(last_pcsrc), 1);
    chk("beq_taken_lat", last_lat, 3);
    run_instr(6'b110100, 0, 0, 0, 0, -1, h);
    chk("beq_not_pcsrc", int'(last_pcsrc), 0);
    run_instr(6'b111010, 0, 0, 0, 0, -1, h);
    chk("jal_lat", last_lat, 2);
    chk("jal_pcsrc", int'(last_pcsrc), 3);
    chk("jal_regwre", int'(last_regwre), 1);
    run_instr(6'b101010, 0, 0, 0, 0, -1, h);
    chk("illegal_halted", int'(halted), 1);
    chk("illegal_ill_op", int'(ill_op), 1);
    do_reset(2);
    chk("post_reset_ill_op", int'(ill_op), 0);
    chk("post_reset_state", int'(State), 0);
`ifdef MC_CTRL_WDOG_EN
    run_instr(6'b000000, 0, 0, 100, 0, -1, h);
    chk("wdog_halted", int'(halted), 1);
    chk("wdog_bus_err", int'(bus_err), 1);
    do_reset(2);
    run_instr(6'b000000, 0, 0, WDOG - 1, 0, -1, h);
    chk("wdog_last_ack_lat", last_lat, 4 + WDOG - 1);
`else
    run_instr(6'b000000, 0, 0, 20, 0, -1, h);
    chk("long_wait_lat", last_lat, 24);
    chk("long_wait_bus_err", int'(bus_err), 0);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      int iw, dw, ab;
      op = ($urandom_range(0, 4) != 0) ? legal_ops[$urandom_range(0, 17)]
                                       : 6'($urandom_range(0, 63));
      iw = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 5);
      dw = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 5);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 6) : -1;
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), iw, dw, ab, h);
      if (h) do_reset(1 + $urandom_range(0, 1));
    end

    @(posedge CLK); #1;
    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
